comparator: RTL and testbench

//  - BIST read-check comparator. Compares expected (etalon) data against data read back from the memory under test.
//  - Flags a mismatch only while a read is being checked.
//  - Sits between the BIST pattern generator/controller and the BIST result/status logic.
//  - Outputs are registered; it also keeps a sticky fail flag, a mismatch bit mask and an error count.

---
 rtl/bist_pkg.sv | 14 +
 rtl/sat_counter.sv | 45 ++++
 rtl/comparator.sv | 105 ++++++++++
 tb/tb_comparator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// ============================================================================
// Module : bist_pkg
// Shared BIST widths and the saturation limit of the error counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bist_pkg;
  localparam int DTA_SIZE_DEF = 8;
  localparam int CNT_W_DEF    = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Saturating up-counter with synchronous clear and asynchronous reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
  import bist_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over increment; the count parks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/comparator.sv
// ============================================================================
// Module : comparator
// BIST read-check comparator: registered error flag, sticky fail, mismatch
// mask and saturating error count. COMPARATOR_FIRST_FAIL_EN adds capture of
// the first failing data pair (first_et / first_read).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator
  import bist_pkg::*;
#(
  parameter int DTA_SIZE = DTA_SIZE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DTA_SIZE-1:0] data_et,
  input  logic [DTA_SIZE-1:0] data_read,
  input  logic                read_en,
  input  logic                clr,
  output logic                error,
  output logic                fail,
  output logic [DTA_SIZE-1:0] mismatch_mask,
  output logic [CNT_W-1:0]    err_count
`ifdef COMPARATOR_FIRST_FAIL_EN
  ,
  output logic [DTA_SIZE-1:0] first_et,
  output logic [DTA_SIZE-1:0] first_read
`endif
);

  logic                cmp;
  logic                error_q;
  logic                fail_q;
  logic                fail_d;
  logic [DTA_SIZE-1:0] mask_q;
  logic [DTA_SIZE-1:0] mask_d;

  assign cmp = read_en && (data_et != data_read);

  always_comb begin
    fail_d = fail_q;
    if (clr) begin
      fail_d = 1'b0;
    end else if (cmp) begin
      fail_d = 1'b1;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (read_en) begin
      mask_d = data_et ^ data_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
      fail_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      error_q <= cmp;
      fail_q  <= fail_d;
      mask_q  <= mask_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (cmp),
    .clr_i   (clr),
    .count_o (err_count)
  );

`ifdef COMPARATOR_FIRST_FAIL_EN
  logic [DTA_SIZE-1:0] first_et_q;
  logic [DTA_SIZE-1:0] first_read_q;

  // Capture only the mismatch that sets fail; frozen for as long as fail holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_et_q   <= '0;
      first_read_q <= '0;
    end else if (cmp && !clr && !fail_q) begin
      first_et_q   <= data_et;
      first_read_q <= data_read;
    end
  end

  assign first_et   = first_et_q;
  assign first_read = first_read_q;
`endif

  assign error         = error_q;
  assign fail          = fail_q;
  assign mismatch_mask = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_comparator.sv
// ============================================================================
// Module : tb_comparator
// Directed and randomized bench for comparator with a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparator;
  import bist_pkg::*;

  localparam int W  = DTA_SIZE_DEF;
  localparam int CW = CNT_W_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_et;
  logic [W-1:0]  data_read;
  logic          read_en;
  logic          clr;
  logic          error;
  logic          fail;
  logic [W-1:0]  mismatch_mask;
  logic [CW-1:0] err_count;
`ifdef COMPARATOR_FIRST_FAIL_EN
  logic [W-1:0]  first_et;
  logic [W-1:0]  first_read;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic          m_error;
  logic          m_fail;
  logic [W-1:0]  m_mask;
  int            m_cnt;
  logic [W-1:0]  m_fet;
  logic [W-1:0]  m_frd;

  always #5 clk = ~clk;

  comparator dut (
    .clk           (clk),
    .rst           (rst),
    .data_et       (data_et),
    .data_read     (data_read),
    .read_en       (read_en),
    .clr           (clr),
    .error         (error),
    .fail          (fail),
    .mismatch_mask (mismatch_mask),
    .err_count     (err_count)
`ifdef COMPARATOR_FIRST_FAIL_EN
    ,
    .first_et      (first_et),
    .first_read    (first_read)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_error = 1'b0;
    m_fail  = 1'b0;
    m_mask  = '0;
    m_cnt   = 0;
    m_fet   = '0;
    m_frd   = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".error"}, 32'(error), 32'(m_error));
    chk({tag, ".fail"}, 32'(fail), 32'(m_fail));
    chk({tag, ".mask"}, 32'(mismatch_mask), 32'(m_mask));
    chk({tag, ".count"}, 32'(err_count), 32'(m_cnt));
`ifdef COMPARATOR_FIRST_FAIL_EN
    chk({tag, ".first_et"}, 32'(first_et), 32'(m_fet));
    chk({tag, ".first_read"}, 32'(first_read), 32'(m_frd));
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the specified rules.
  task automatic step(input logic en, input logic [W-1:0] et, input logic [W-1:0] rd,
                      input logic c, input bit do_check, input string tag);
    bit mism;
    @(negedge clk);
    read_en   = en;
    data_et   = et;
    data_read = rd;
    clr       = c;
    @(posedge clk);
    mism    = en && (et != rd);
    m_error = mism;
    if (en) m_mask = et ^ rd;
    if (!c && mism && !m_fail) begin
      m_fet = et;
      m_frd = rd;
    end
    if (c) begin
      m_fail = 1'b0;
      m_cnt  = 0;
    end else if (mism) begin
      m_fail = 1'b1;
      m_cnt  = (m_cnt == int'(CNT_MAX)) ? int'(CNT_MAX) : m_cnt + 1;
    end
    #1;
    if (do_check) check_all(tag);
  endtask

  initial begin
    logic [W-1:0] et;
    logic [W-1:0] rd;
    logic [W-1:0] flip;

    rst = 1'b1; read_en = 1'b0; clr = 1'b0; data_et = '0; data_read = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h08, 8'h00, 1'b0, 1'b1, "idle_diff");
    step(1'b0, 8'h08, 8'h00, 1'b0, 1'b1, "idle_diff2");

    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, "eq_00");
    step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, "eq_FF");
    step(1'b1, 8'h10, 8'h10, 1'b0, 1'b1, "eq_10");
    step(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1, "eq_7F");

    step(1'b1, 8'h08, 8'h00, 1'b0, 1'b1, "mis_08");
    chk("mis_08.mask_lit", 32'(mismatch_mask), 32'h08);
    step(1'b1, 8'h55, 8'h55, 1'b0, 1'b1, "eq_55");
    step(1'b1, 8'h01, 8'h03, 1'b0, 1'b1, "mis_01_03");
`ifdef COMPARATOR_FIRST_FAIL_EN
    chk("first_et_lit", 32'(first_et), 32'h08);
    chk("first_read_lit", 32'(first_read), 32'h00);
`endif
    step(1'b0, 8'hAA, 8'h55, 1'b0, 1'b1, "en0_hold_mask");

    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, "clr");
    step(1'b1, 8'hC3, 8'h3C, 1'b1, 1'b1, "clr_vs_cmp");

    for (int b = 0; b < W; b++) begin
      et = W'($urandom);
      step(1'b1, et, et ^ (W'(1) << b), 1'b0, 1'b1, $sformatf("bit%0d", b));
    end

    for (int i = 0; i < 300; i++) begin
      et = W'($urandom);
      rd = ($urandom_range(0, 2) == 0) ? et : W'($urandom);
      step(1'($urandom_range(0, 3) != 0), et, rd, 1'($urandom_range(0, 15) == 0),
           1'b1, "rand");
    end

    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, "pre_sat_clr");
    for (int i = 0; i < int'(CNT_MAX) + 3; i++) begin
      et   = W'($urandom);
      flip = W'($urandom_range(1, (1 << W) - 1));
      step(1'b1, et, et ^ flip, 1'b0, 1'b0, "sat");
    end
    check_all("saturated");
    chk("saturated.lit", 32'(err_count), 32'(CNT_MAX));
    step(1'b1, 8'h0F, 8'h00, 1'b0, 1'b1, "sat_more");

    // Asynchronous reset mid-cycle while error is high
    step(1'b1, 8'h80, 8'h00, 1'b0, 1'b1, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    read_en = 1'b0;
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
